// File: rtl/unit_input_distrib.sv
// unit_input_distrib
//   Round-robin packet distributor. Pulls whole packets from a first-word-
//   fall-through host FIFO and forwards each one to a single unit that has an
//   idle thread, then moves on to the next unit. Data and end-of-packet flag
//   are broadcast to all units; only the write enable is one-hot.
//
// Ports
//   CLK, RESET_N    clock, asynchronous active-low reset
//   in_data/in_ctrl head word of the host FIFO / last-word flag
//   in_empty        host FIFO empty
//   in_rd_en        host FIFO pop (combinational)
//   unit_in         broadcast data word (registered)
//   unit_in_ctrl    broadcast end-of-packet flag (registered)
//   unit_in_wr_en   one-hot write enable per unit (registered)
//   unit_in_afull   per-unit almost-full (at least 2 words of slack)
//   unit_in_ready   per-unit "idle thread, accepts a new packet"
//   pkt_cnt         packets dispatched, wraps at 16 bits
//   err_pkt_len     sticky: a packet reached MAX_PKT_WORDS without in_ctrl
`ifndef UNIT_INPUT_WIDTH
`define UNIT_INPUT_WIDTH 32
`endif

module unit_input_distrib #(
  parameter int N_UNITS       = 4,
  parameter int WIDTH         = `UNIT_INPUT_WIDTH,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_ctrl,
  input  logic               in_empty,
  output logic               in_rd_en,
  output logic [WIDTH-1:0]   unit_in,
  output logic               unit_in_ctrl,
  output logic [N_UNITS-1:0] unit_in_wr_en,
  input  logic [N_UNITS-1:0] unit_in_afull,
  input  logic [N_UNITS-1:0] unit_in_ready,
  output logic [15:0]        pkt_cnt,
  output logic               err_pkt_len
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(N_UNITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PKT_WORDS);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_SEND   = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] word_cnt_nxt;
  logic             cand_ok;

  function automatic logic [PTR_W-1:0] next_unit(input logic [PTR_W-1:0] u);
    return (u == LAST_UNIT) ? '0 : u + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [N_UNITS-1:0] onehot(input logic [PTR_W-1:0] u);
    logic [N_UNITS-1:0] r;
    r    = '0;
    r[u] = 1'b1;
    return r;
  endfunction

  // Candidate under examination this cycle (one per cycle while searching).
  assign cand_ok = unit_in_ready[ptr] & ~unit_in_afull[ptr];

  // Pop only while a unit is reserved; afull of the reserved unit stalls.
  assign in_rd_en = (state == ST_SEND) & ~in_empty & ~unit_in_afull[sel];

  assign word_cnt_nxt = sat_inc(word_cnt);

  // Popped word -> registered broadcast one cycle later
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= ST_SEARCH;
      ptr           <= '0;
      sel           <= '0;
      word_cnt      <= '0;
      unit_in       <= '0;
      unit_in_ctrl  <= 1'b0;
      unit_in_wr_en <= '0;
      pkt_cnt       <= '0;
      err_pkt_len   <= 1'b0;
    end else begin
      unit_in_wr_en <= '0;
      if (state == ST_SEARCH) begin
        // The unit is reserved as soon as it qualifies, even with no data yet.
        if (cand_ok) begin
          sel      <= ptr;
          word_cnt <= '0;
          state    <= ST_SEND;
        end else begin
          ptr <= next_unit(ptr);
        end
      end else if (in_rd_en) begin
        unit_in       <= in_data;
        unit_in_ctrl  <= in_ctrl;
        unit_in_wr_en <= onehot(sel);
        word_cnt      <= word_cnt_nxt;
        // Forwarding continues after an over-length packet; only flag it.
        if (word_cnt_nxt == CNT_MAX && !in_ctrl)
          err_pkt_len <= 1'b1;
        if (in_ctrl) begin
          pkt_cnt <= pkt_cnt + 16'd1;
          ptr     <= next_unit(sel);
          state   <= ST_SEARCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_unit_input_distrib.sv
module tb_unit_input_distrib;

  localparam int N_UNITS = 4;
  localparam int WIDTH   = 32;
  localparam int MAXW    = 8;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic [WIDTH-1:0]   in_data;
  logic               in_ctrl;
  logic               in_empty;
  logic               in_rd_en;
  logic [WIDTH-1:0]   unit_in;
  logic               unit_in_ctrl;
  logic [N_UNITS-1:0] unit_in_wr_en;
  logic [N_UNITS-1:0] unit_in_afull;
  logic [N_UNITS-1:0] unit_in_ready;
  logic [15:0]        pkt_cnt;
  logic               err_pkt_len;

  unit_input_distrib #(
    .N_UNITS(N_UNITS), .WIDTH(WIDTH), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .unit_in(unit_in), .unit_in_ctrl(unit_in_ctrl), .unit_in_wr_en(unit_in_wr_en),
    .unit_in_afull(unit_in_afull), .unit_in_ready(unit_in_ready),
    .pkt_cnt(pkt_cnt), .err_pkt_len(err_pkt_len)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Host FWFT FIFO model
  logic [WIDTH:0] mem [0:255];
  logic [7:0]     wr_ptr;
  logic [7:0]     rd_ptr = '0;
  logic           hold_empty = 1'b0;
  logic           toggle_en;

  assign in_empty = (rd_ptr == wr_ptr) | hold_empty;
  assign {in_ctrl, in_data} = mem[rd_ptr];

  always @(posedge CLK) begin
    if (!RESET_N) rd_ptr <= wr_ptr;
    else if (in_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  always @(posedge CLK) hold_empty <= toggle_en ? ~hold_empty : 1'b0;

  // Scoreboard
  typedef struct packed {
    logic [N_UNITS-1:0] we;
    logic [WIDTH-1:0]   data;
    logic               ctrl;
    logic               err;
    logic [15:0]        cnt;
  } exp_t;

  exp_t exp_q[$];
  int   wlog[$];
  int   total = 0;
  int   bad   = 0;
  int   cnt_m;
  logic err_m;
  exp_t mon_e;
  int   R;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_pkt(input int unit, input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic last;
      exp_t e;
      last = (i == n - 1);
      mem[wr_ptr] = {last, base + WIDTH'(i)};
      wr_ptr = wr_ptr + 8'd1;
      if (i + 1 == MAXW && !last) err_m = 1'b1;
      if (last) cnt_m++;
      e.we   = N_UNITS'(1) << unit;
      e.data = base + WIDTH'(i);
      e.ctrl = last;
      e.err  = err_m;
      e.cnt  = 16'(cnt_m);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge CLK);
      b++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (RESET_N && unit_in_wr_en != '0) begin
      wlog.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(unit_in_wr_en), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_en",   64'(unit_in_wr_en), 64'(mon_e.we));
        chk("data",    64'(unit_in),       64'(mon_e.data));
        chk("ctrl",    64'(unit_in_ctrl),  64'(mon_e.ctrl));
        chk("err_len", 64'(err_pkt_len),   64'(mon_e.err));
        chk("pkt_cnt", 64'(pkt_cnt),       64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int b;
    RESET_N = 1'b0; unit_in_ready = '0; unit_in_afull = '0; toggle_en = 1'b0;
    wr_ptr = '0; cnt_m = 0; err_m = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wr_en",   64'(unit_in_wr_en), 64'd0);
    chk("rst_unit_in", 64'(unit_in),       64'd0);
    chk("rst_ctrl",    64'(unit_in_ctrl),  64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt),       64'd0);
    chk("rst_err",     64'(err_pkt_len),   64'd0);
    chk("rst_rd_en",   64'(in_rd_en),      64'd0);

    // Only unit 3 ready: scan 0,1,2 fail, 3 selected; then 0,1,2 round robin.
    unit_in_ready = 4'b1000;
    RESET_N = 1'b1;
    R = cyc;
    push_pkt(3, 4, 32'h3000_0000);
    push_pkt(0, 5, 32'h1000_0000);
    push_pkt(1, 5, 32'h1100_0000);
    push_pkt(2, 5, 32'h1200_0000);
    b = 0;
    while (wlog.size() == 0 && b < 50) begin
      @(posedge CLK);
      b++;
    end
    #1;
    unit_in_ready = 4'b1111;
    drain("rr");
    chk("rr_writes", 64'(wlog.size()), 64'd19);
    if (wlog.size() == 19) begin
      chk("first_write_cyc", 64'(wlog[0]),  64'(R + 5));
      chk("pkt0_start_cyc",  64'(wlog[4]),  64'(R + 10));
      chk("pkt1_start_cyc",  64'(wlog[9]),  64'(R + 16));
      chk("pkt2_start_cyc",  64'(wlog[14]), 64'(R + 22));
      chk("pkt2_end_cyc",    64'(wlog[18]), 64'(R + 26));
    end
    chk("rr_pkt_cnt", 64'(pkt_cnt), 64'd4);

    // afull on the selected unit (3) for 4 cycles mid-packet.
    wlog.delete();
    push_pkt(3, 6, 32'h4000_0000);
    b = 0;
    while (exp_q.size() > 4 && b < 50) begin
      @(posedge CLK);
      b++;
    end
    #1;
    unit_in_afull = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("afull_rd_en", 64'(in_rd_en), 64'd0);
      if (i > 0) chk("afull_wr_en", 64'(unit_in_wr_en), 64'd0);
      @(posedge CLK);
      #1;
    end
    unit_in_afull = '0;
    @(negedge CLK);
    chk("afull_wr_en_last", 64'(unit_in_wr_en), 64'd0);
    drain("afull");
    chk("afull_writes", 64'(wlog.size()), 64'd6);
    chk("afull_pkt_cnt", 64'(pkt_cnt), 64'd5);

    // in_empty toggling every other cycle, 6-word packet to unit 0.
    wlog.delete();
    toggle_en = 1'b1;
    push_pkt(0, 6, 32'h5000_0000);
    drain("empty");
    toggle_en = 1'b0;
    chk("empty_writes", 64'(wlog.size()), 64'd6);
    if (wlog.size() == 6) chk("empty_spacing", 64'(wlog[5] - wlog[0]), 64'd10);
    chk("empty_pkt_cnt", 64'(pkt_cnt), 64'd6);

    // 10-word packet exceeds MAX_PKT_WORDS=8; a later legal packet still counts.
    wlog.delete();
    push_pkt(1, 10, 32'h6000_0000);
    push_pkt(2, 3, 32'h7000_0000);
    drain("len");
    chk("len_writes", 64'(wlog.size()), 64'd13);
    chk("len_err", 64'(err_pkt_len), 64'd1);
    chk("len_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // Reset for one cycle in the middle of a packet to unit 3.
    push_pkt(3, 6, 32'h8000_0000);
    b = 0;
    while (exp_q.size() > 4 && b < 50) begin
      @(posedge CLK);
      b++;
    end
    #1;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_wr_en",   64'(unit_in_wr_en), 64'd0);
    chk("mid_rst_unit_in", 64'(unit_in),       64'd0);
    chk("mid_rst_ctrl",    64'(unit_in_ctrl),  64'd0);
    chk("mid_rst_pkt_cnt", 64'(pkt_cnt),       64'd0);
    chk("mid_rst_err",     64'(err_pkt_len),   64'd0);
    exp_q.delete();
    cnt_m = 0;
    err_m = 1'b0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    push_pkt(0, 3, 32'h9000_0000);
    drain("post_rst");
    chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("post_rst_err", 64'(err_pkt_len), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unit_input_distrib.md
# unit_input_distrib

Round-robin packet distributor placed directly upstream of the per-unit input ports (`unit_in`, `unit_in_ctrl`, `unit_in_wr_en`, `unit_in_afull`, `unit_in_ready`).
- Takes the packet stream from the host input FIFO (first-word-fall-through) and selects a unit that has an idle thread.
- Forwards one whole packet to that unit, then moves on to the next unit.
- Packets are never split between units.
- The broadcast data bus is shared by all units; only the write enable is one-hot.

## Interface
Parameters:
- N_UNITS, 4: number of units served (≥2).
- WIDTH, `UNIT_INPUT_WIDTH`: data word width.
- MAX_PKT_WORDS, 256: packet-length limit used for error detection.

Ports:
- Clocking (already decided): one clock, `CLK`; reset `RESET_N` is asynchronous and active-low.
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  head word of the host input FIFO.
- in_ctrl  in  1  set on the last word of a packet.
- in_empty  in  1  host FIFO empty.
- in_rd_en  out  1  pops the host FIFO (combinational).
- unit_in  out  WIDTH  broadcast data to all units (registered).
- unit_in_ctrl  out  1  broadcast end-of-packet flag (registered).
- unit_in_wr_en  out  N_UNITS  one-hot write enable (registered).
- unit_in_afull  in  N_UNITS  unit input almost-full; leaves ≥2 words of slack.
- unit_in_ready  in  N_UNITS  unit has an idle thread and accepts a new packet.
- pkt_cnt  out  16  packets dispatched; wraps 0xFFFF→0.
- err_pkt_len  out  1  sticky: a packet reached MAX_PKT_WORDS words without in_ctrl.

## Operation
State machine:
- SEARCH (reset state), scanning candidate ptr:
  - If unit_in_ready[ptr] & ~unit_in_afull[ptr]: sel←ptr, go to SEND.
  - Otherwise: ptr←ptr+1, wrapping N_UNITS-1→0.
  - One candidate is examined per cycle.
- SEND:
  - in_rd_en = ~in_empty & ~unit_in_afull[sel].
  - On each popped word, the next cycle drives unit_in←in_data, unit_in_ctrl←in_ctrl, unit_in_wr_en←onehot(sel).
  - Popped word with in_ctrl=1: pkt_cnt++, ptr←sel+1 (with wrap), go to SEARCH.
- in_rd_en is 0 in SEARCH.
- SEND is entered without waiting for in_empty=0: the unit is reserved once chosen, even if no data is present yet.
- unit_in_ready[sel] is ignored while in SEND; a deassertion mid-packet does not abort.
- unit_in_afull[sel] asserted stalls popping. The stall persists indefinitely while afull stays high.
- Word counter:
  - Cleared on entry to SEND; incremented per popped word, saturating at MAX_PKT_WORDS.
  - Reaching MAX_PKT_WORDS with the current word's in_ctrl=0 sets err_pkt_len.
  - err_pkt_len clears only on reset; forwarding continues unchanged.
- A single-word packet (in_ctrl=1 on the first word) is legal.
- Reset:
  - State=SEARCH, ptr=0, sel=0, unit_in_wr_en=0, unit_in=0, unit_in_ctrl=0, pkt_cnt=0, err_pkt_len=0.
  - A packet partly delivered at reset is truncated; unit reset is handled externally.

## Timing
- in_rd_en is combinational from state, in_empty and unit_in_afull[sel] in the same cycle.
- Pop-to-unit-write latency is 1 cycle. Throughput within a packet is 1 word/cycle.
- SEARCH→SEND takes 1 cycle after a qualifying candidate is sampled.
- Minimum gap between the last word of one packet and the first word of the next is 1 SEARCH cycle (2 cycles between the unit_in_wr_en pulses).
- Worst-case search is N_UNITS cycles per full revolution with no qualifying unit; the scan loops until one qualifies.
- unit_in_afull is sampled the same cycle as the pop; the registered write lands 1 cycle later, covered by the ≥2-word slack.
- pkt_cnt updates in the cycle after the in_ctrl word is popped, coincident with that word's unit_in_wr_en.

## Test plan
- All 4 units ready, host sends three 5-word packets back to back.
  - Packets go to units 0, 1, 2.
  - unit_in_wr_en = 0001 ×5, 0010 ×5, 0100 ×5.
  - Exactly 1 idle cycle between packets; pkt_cnt=3.
- unit_in_ready = 1000 only.
  - ptr steps 0→1→2→3, taking 3 SEARCH cycles before selection.
  - Packet is delivered entirely to unit 3; next search starts at 0.
- unit_in_afull[sel] asserted for 4 cycles mid-packet.
  - in_rd_en=0 and no unit_in_wr_en for those 4 cycles.
  - Remaining words resume in order; no word is lost or duplicated.
- in_empty toggling every other cycle during a 6-word packet.
  - Exactly 6 writes to one unit; in_ctrl arrives only on the 6th.
- MAX_PKT_WORDS=8, 10-word packet.
  - err_pkt_len rises on the 8th word and stays 1.
  - All 10 words are forwarded; a later legal packet still increments pkt_cnt.
- RESET_N low for 1 cycle mid-packet.
  - All outputs go to reset values immediately (asynchronous).
  - After release, the next packet goes to unit 0 with pkt_cnt=1.
